// File: rtl/acc_alu_unit.sv
// acc_alu_unit: accumulator file, operand/data/result latches, 3-bit ALU and C/Z/N flags
module acc_alu_unit #(
    parameter int DATA_W  = 8,
    parameter int NUM_ACC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        irDst,
    input  logic [1:0]        irSrc,
    input  logic [DATA_W-1:0] irImm,
    input  logic [1:0]        ACaddressSel,
    input  logic [1:0]        ACdataSel,
    input  logic              ACwrite,
    input  logic              ACread,
    input  logic              memRead,
    input  logic [DATA_W-1:0] memData,
    input  logic              ALUBinputSel,
    input  logic [2:0]        ALUcommand,
    input  logic              aluGo,
    input  logic              resultRegEn,
    input  logic              dataRegEn,
    input  logic              wordRegEn,
    input  logic              CEn,
    input  logic              ZEn,
    input  logic              NEn,
    output logic [DATA_W-1:0] storeData,
    output logic              cFlag,
    output logic              zFlag,
    output logic              nFlag,
    output logic              illegalCmd
);
    logic [DATA_W-1:0] acc [NUM_ACC];
    logic [DATA_W-1:0] op_a_reg, data_reg, result_reg;
    logic [DATA_W-1:0] rd_data, wr_data, alu_b, alu_out;
    logic [DATA_W:0]   sum;
    logic [1:0]        addr;
    logic              no_acc, legal;

    // address/data muxes and ALU datapath
    always_comb begin
        addr    = ACaddressSel == 2'd0 ? 2'd0 : ACaddressSel == 2'd1 ? irDst : irSrc;
        no_acc  = ACaddressSel == 2'd3;
        rd_data = no_acc ? '0 : acc[addr];
        wr_data = ACdataSel == 2'd0 ? data_reg : ACdataSel == 2'd1 ? result_reg :
                  ACdataSel == 2'd2 ? op_a_reg : irImm;
        alu_b   = ALUBinputSel ? data_reg : rd_data;
        sum     = {1'b0, op_a_reg} + {1'b0, alu_b} + {{DATA_W{1'b0}}, cFlag};
        alu_out = ALUcommand == 3'd0 ? sum[DATA_W-1:0] :
                  ALUcommand == 3'd1 ? (op_a_reg & alu_b) :
                  ALUcommand == 3'd2 ? (op_a_reg | alu_b) :
                  ALUcommand == 3'd3 ? alu_b : ~op_a_reg;
        legal   = ALUcommand <= 3'd4;
    end

    // accumulator file; reads above see the pre-write value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
        end else if (ACwrite && !no_acc) begin
            acc[addr] <= wr_data;
        end
    end

    // operand and memory data latches; irSrc reads only feed the ALU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_reg <= '0;
            data_reg <= '0;
        end else begin
            if (ACread && wordRegEn && !ACaddressSel[1]) op_a_reg <= rd_data;
            if (memRead && dataRegEn) data_reg <= memData;
        end
    end

    // ALU commit: result, flags and the reserved-command pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_reg <= '0;
            cFlag      <= 1'b0;
            zFlag      <= 1'b0;
            nFlag      <= 1'b0;
            illegalCmd <= 1'b0;
        end else begin
            illegalCmd <= aluGo && !legal;
            if (aluGo && legal) begin
                if (resultRegEn) result_reg <= alu_out;
                if (CEn && ALUcommand == 3'd0) cFlag <= sum[DATA_W];
                if (ZEn) zFlag <= alu_out == '0;
                if (NEn) nFlag <= alu_out[DATA_W-1];
            end
        end
    end

    assign storeData = op_a_reg;
endmodule

// File: tb/tb_acc_alu_unit.sv
// tb_acc_alu_unit: directed + random traffic checked against a queued behavioural model
module tb_acc_alu_unit;
    logic       clk, rst;
    logic [1:0] irDst, irSrc, ACaddressSel, ACdataSel;
    logic [7:0] irImm, memData, storeData;
    logic       ACwrite, ACread, memRead, ALUBinputSel, aluGo;
    logic [2:0] ALUcommand;
    logic       resultRegEn, dataRegEn, wordRegEn, CEn, ZEn, NEn;
    logic       cFlag, zFlag, nFlag, illegalCmd;

    int compared = 0, mismatched = 0;
    logic [11:0] exp_q [$];

    logic [7:0] m_acc [4];
    logic [7:0] m_opa, m_dat, m_res;
    logic       m_c, m_z, m_n, m_ill;

    acc_alu_unit dut (
        .clk(clk), .rst(rst), .irDst(irDst), .irSrc(irSrc), .irImm(irImm),
        .ACaddressSel(ACaddressSel), .ACdataSel(ACdataSel), .ACwrite(ACwrite),
        .ACread(ACread), .memRead(memRead), .memData(memData),
        .ALUBinputSel(ALUBinputSel), .ALUcommand(ALUcommand), .aluGo(aluGo),
        .resultRegEn(resultRegEn), .dataRegEn(dataRegEn), .wordRegEn(wordRegEn),
        .CEn(CEn), .ZEn(ZEn), .NEn(NEn), .storeData(storeData),
        .cFlag(cFlag), .zFlag(zFlag), .nFlag(nFlag), .illegalCmd(illegalCmd)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_acc[i] = 8'h00;
        m_opa = 0; m_dat = 0; m_res = 0;
        m_c = 0; m_z = 0; m_n = 0; m_ill = 0;
    endtask

    task automatic idle();
        irDst = 0; irSrc = 0; irImm = 0; memData = 0;
        ACaddressSel = 3; ACdataSel = 0; ACwrite = 0; ACread = 0; memRead = 0;
        ALUBinputSel = 0; ALUcommand = 0; aluGo = 0;
        resultRegEn = 0; dataRegEn = 0; wordRegEn = 0; CEn = 0; ZEn = 0; NEn = 0;
    endtask

    // apply the current inputs to the model, queue the post-edge state, advance a cycle
    task automatic step();
        logic [1:0] a;
        logic [7:0] rd, wd, b, o;
        int s;
        a  = ACaddressSel == 0 ? 2'd0 : ACaddressSel == 1 ? irDst : irSrc;
        rd = ACaddressSel == 3 ? 8'h00 : m_acc[a];
        case (ACdataSel)
            0: wd = m_dat;
            1: wd = m_res;
            2: wd = m_opa;
            default: wd = irImm;
        endcase
        b = ALUBinputSel ? m_dat : rd;
        s = int'(m_opa) + int'(b) + int'(m_c);
        case (ALUcommand)
            0: o = s[7:0];
            1: o = m_opa & b;
            2: o = m_opa | b;
            3: o = b;
            default: o = ~m_opa;
        endcase
        m_ill = aluGo && ALUcommand > 4;
        if (aluGo && ALUcommand <= 4) begin
            if (resultRegEn) m_res = o;
            if (CEn && ALUcommand == 0) m_c = s > 255;
            if (ZEn) m_z = o == 0;
            if (NEn) m_n = o[7];
        end
        if (ACwrite && ACaddressSel != 3) m_acc[a] = wd;
        if (ACread && wordRegEn && ACaddressSel < 2) m_opa = rd;
        if (memRead && dataRegEn) m_dat = memData;
        exp_q.push_back({m_opa, m_c, m_z, m_n, m_ill});
        @(negedge clk);
    endtask

    task automatic ldi(input logic [1:0] idx, input logic [7:0] v);
        idle(); ACaddressSel = 1; irDst = idx; ACdataSel = 3; irImm = v; ACwrite = 1; step();
    endtask

    task automatic rd_acc(input logic [1:0] sel, input logic [1:0] dst);
        idle(); ACaddressSel = sel; irDst = dst; ACread = 1; wordRegEn = 1; step();
    endtask

    task automatic mem_ld(input logic [7:0] v);
        idle(); memRead = 1; dataRegEn = 1; memData = v; step();
    endtask

    task automatic alu(input logic [2:0] cmd, input logic bsel, input logic [1:0] src, input logic cen);
        idle(); aluGo = 1; ALUcommand = cmd; ALUBinputSel = bsel;
        ACaddressSel = bsel ? 2'd3 : 2'd2; irSrc = src;
        resultRegEn = 1; CEn = cen; ZEn = 1; NEn = 1; step();
    endtask

    task automatic wr_res(input logic [1:0] dst);
        idle(); ACaddressSel = 1; irDst = dst; ACdataSel = 1; ACwrite = 1; step();
    endtask

    // monitor: pop one expectation per presented cycle and compare
    initial begin
        logic [11:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {storeData, cFlag, zFlag, nFlag, illegalCmd};
                compared++;
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL state t=%0t got store=%h c/z/n/ill=%b expected store=%h c/z/n/ill=%b",
                             $time, g[11:4], g[3:0], e[11:4], e[3:0]);
                end
            end
        end
    end

    initial begin
        rst = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        // preload 11,22,33,44 and make outputs nonzero before the async reset
        ldi(0, 8'd11); ldi(1, 8'd22); ldi(2, 8'd33); ldi(3, 8'd44);
        rd_acc(1, 3);
        alu(4, 0, 0, 1);
        #1 rst = 0;
        model_reset();
        #1;
        compared++;
        if ({storeData, cFlag, zFlag, nFlag, illegalCmd} !== 12'h000) begin
            mismatched++;
            $display("FAIL async_reset got store=%h c/z/n/ill=%b%b%b%b expected all zero",
                     storeData, cFlag, zFlag, nFlag, illegalCmd);
        end
        #1 rst = 1;
        for (int i = 0; i < 4; i++) rd_acc(1, 2'(i));
        // LDA then STA path
        mem_ld(8'h5A);
        idle(); ACaddressSel = 0; ACdataSel = 0; ACwrite = 1; step();
        rd_acc(0, 0);
        // ADD chain with carry in
        ldi(0, 8'hF0); rd_acc(0, 0); mem_ld(8'h20);
        alu(0, 1, 0, 1); wr_res(2); rd_acc(1, 2);
        rd_acc(0, 0); alu(0, 1, 0, 1); wr_res(2); rd_acc(1, 2);
        // register-operand logic ops and CEn=0 overflow
        ldi(1, 8'h0F); ldi(2, 8'hF0); rd_acc(1, 1);
        alu(1, 0, 2, 1);
        alu(2, 0, 2, 1);
        alu(3, 0, 2, 1);
        alu(0, 0, 2, 1);
        mem_ld(8'h01); ldi(0, 8'h00); rd_acc(0, 0);
        alu(0, 1, 0, 1);
        ldi(0, 8'hFF); rd_acc(0, 0);
        alu(0, 1, 0, 0);
        wr_res(1); rd_acc(1, 1);
        // same-edge write/read hazard and suppressed write
        ldi(3, 8'h44);
        idle(); ACaddressSel = 1; irDst = 3; ACdataSel = 3; irImm = 8'h77;
        ACwrite = 1; ACread = 1; wordRegEn = 1; step();
        rd_acc(1, 3);
        idle(); ACaddressSel = 1; irDst = 3; ACdataSel = 2; ACwrite = 1; ACread = 1; wordRegEn = 1;
        ldi(3, 8'h12); step();
        rd_acc(1, 3);
        idle(); ACaddressSel = 3; ACdataSel = 3; irImm = 8'hAA; ACwrite = 1; ACread = 1; wordRegEn = 1; step();
        for (int i = 0; i < 4; i++) rd_acc(1, 2'(i));
        // reserved command pulses illegalCmd once
        alu(6, 1, 0, 1);
        idle(); step();
        alu(7, 0, 1, 1);
        alu(5, 0, 1, 1);
        idle(); step();
        // random traffic
        for (int k = 0; k < 500; k++) begin
            irDst = 2'($urandom); irSrc = 2'($urandom); irImm = 8'($urandom);
            memData = 8'($urandom); ACaddressSel = 2'($urandom); ACdataSel = 2'($urandom);
            ACwrite = 1'($urandom); ACread = 1'($urandom); memRead = 1'($urandom);
            ALUBinputSel = 1'($urandom); ALUcommand = 3'($urandom_range(0, 7));
            aluGo = 1'($urandom); resultRegEn = 1'($urandom); dataRegEn = 1'($urandom);
            wordRegEn = 1'($urandom); CEn = 1'($urandom); ZEn = 1'($urandom); NEn = 1'($urandom);
            step();
        end
        idle();
        repeat (2) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/acc_alu_unit.md
Name: acc_alu_unit

Overview:
- Accumulator datapath directly downstream of the multicycle controller: 4-entry accumulator file, operand/data/result latches, 3-bit-command ALU and C/Z/N flag registers.
- Consumes the controller's AC*/ALU*/enable strobes and the IR register fields.
- Produces store data to memory and flags to the controller/branch logic.
- All state changes on clk rising edge; strobes are sampled, never edge-detected.

Parameters:
- DATA_W, 8, accumulator/memory word width.
- NUM_ACC, 4, accumulator count; fixed by the 2-bit register fields, not to be changed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- irDst  in  2  IR destination-register field.
- irSrc  in  2  IR source-register field.
- irImm  in  DATA_W  IR immediate byte (LDI).
- ACaddressSel  in  2  file address select: 0=acc0, 1=irDst, 2=irSrc, 3=no access.
- ACdataSel  in  2  write-data select: 0=dataReg, 1=resultReg, 2=opAReg, 3=irImm.
- ACwrite  in  1  write file at selected address.
- ACread  in  1  read file at selected address into operand latch.
- memRead  in  1  memory read cycle; memData valid this cycle.
- memData  in  DATA_W  memory read data.
- ALUBinputSel  in  1  ALU B operand: 1=dataReg, 0=file read port.
- ALUcommand  in  3  0=ADD with carry, 1=AND, 2=OR, 3=pass B, 4=NOT A, 5-7 reserved.
- aluGo  in  1  commit ALU output to resultReg and flags this cycle.
- resultRegEn, dataRegEn, wordRegEn  in  1 each  load enables for resultReg, dataReg, opAReg.
- CEn, ZEn, NEn  in  1 each  per-flag update enables.
- storeData  out  DATA_W  = opAReg; memory write data.
- cFlag, zFlag, nFlag  out  1 each  registered flags.
- illegalCmd  out  1  one-cycle pulse on aluGo with reserved command.

Behaviour:
- Reset (rst=0, async): all four accumulators, opAReg, dataReg, resultReg, flags and illegalCmd clear to 0. Reset asserted mid-operation discards any pending write.
- Address mux: combinational from ACaddressSel, irDst and irSrc. Read port rdData = acc[addr]; rdData = 0 when ACaddressSel=3.
- Write: ACwrite=1 and ACaddressSel!=3 writes the selected data into acc[addr] at the edge. ACaddressSel=3 suppresses the write silently.
- Operand latch:
  - ACread=1, wordRegEn=1 and ACaddressSel in {0,1}: opAReg <= rdData.
  - ACaddressSel=2 reads feed the ALU only; opAReg is not loaded.
- Data latch: memRead=1 and dataRegEn=1: dataReg <= memData.
- ALU (combinational): A = opAReg; B = ALUBinputSel ? dataReg : rdData.
  - ADD: {carry,sum} = A + B + cFlag, computed at DATA_W+1 bits; wraps mod 2^DATA_W.
  - AND, OR, pass-B, NOT-A: bitwise; carry out undefined/unused.
- Commit on aluGo=1:
  - Command 0-4 and resultRegEn=1: resultReg <= aluOut.
  - Flags: C <= carry only for ADD and CEn=1; other commands leave C unchanged. Z <= (aluOut==0) if ZEn=1. N <= aluOut[DATA_W-1] if NEn=1.
  - Reserved command: no resultReg or flag update; illegalCmd=1 for that cycle only.
- Same-edge write + read: a read sees the pre-write value (read-before-write). Write data for ACdataSel=2 is the current opAReg, even if opAReg reloads in the same cycle.
- Latency:
  - File write: visible on rdData the cycle after the write edge.
  - ALU: result visible in resultReg and flags one edge after aluGo.
  - Load-to-use: memRead, then ACwrite with ACdataSel=0 in the next cycle (2-cycle LDA).
- No internal FSM dependence on the controller's state. Each strobe acts independently every cycle it is high; holding a strobe repeats its action every cycle.

Test Plan:
- Reset: preload acc0-3 = 11,22,33,44; pulse rst low between edges -> all outputs and acc read 0 immediately, before the next edge.
- LDA/STA: memRead with memData=0x5A, then ACwrite with ACaddressSel=0 and ACdataSel=0 -> acc0=0x5A. Then ACread with sel=0 -> storeData=0x5A.
- ADD chain: opAReg=0xF0, dataReg=0x20, cFlag=0; aluGo with ADD and ALUBinputSel=1 -> resultReg=0x10, C=1, Z=0, N=0. Repeat -> 0x11 (carry in used).
- Register ops: irDst=1 (0x0F), irSrc=2 (0xF0); AND -> Z=1 with C unchanged, OR -> 0xFF with N=1. With CEn=0 on ADD overflow, C keeps its old value.
- Hazards: same-edge ACwrite and ACread to acc3 -> opAReg gets the old value. ACaddressSel=3 write -> no register changes.
- Illegal command: ALUcommand=6 with aluGo -> illegalCmd high exactly 1 cycle; resultReg and flags unchanged.
